// File: rtl/chicken_judge.sv
// chicken_judge: game-rules responder for the board control FSM.
// Judges a flipped card against the tile ahead of the active chicken,
// advances the chicken on request and flags a win when it jumps the opponent.
// Holds the tile layout, both chicken positions and the turn flag.
module chicken_judge #(
   parameter int N_TILES = 24,
   parameter int PIC_W   = 4,
   parameter int POS_W   = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             A,
   input  logic             B,
   input  logic [PIC_W-1:0] card_pic,
   input  logic             tile_we,
   input  logic [POS_W-1:0] tile_addr,
   input  logic [PIC_W-1:0] tile_pic,
   output logic             go,
   output logic             win,
   output logic             done,
   output logic             busy,
   output logic             turn,
   output logic [POS_W-1:0] pos0,
   output logic [POS_W-1:0] pos1
);

   localparam int               AW     = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam logic [POS_W-1:0] LAST   = POS_W'(N_TILES - 1);
   localparam logic [POS_W-1:0] ONE    = POS_W'(1);
   localparam logic [POS_W-1:0] HALF   = POS_W'(N_TILES / 2);
   localparam logic [POS_W:0]   NT_EXT = (POS_W + 1)'(N_TILES);

   typedef enum logic [1:0] {IDLE, JUDGE, MOVE} state_t;

   state_t             state_q, state_d;
   logic               go_q, go_d;
   logic               win_q, win_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               turn_q, turn_d;
   logic [POS_W-1:0]   pos0_q, pos0_d;
   logic [POS_W-1:0]   pos1_q, pos1_d;
   logic [POS_W-1:0]   target_q, target_d;
   logic               jump_q, jump_d;
   logic [PIC_W-1:0]   card_q, card_d;
   logic               tile_wr;
   logic [PIC_W-1:0]   tiles [N_TILES];

   logic [POS_W-1:0]   own, opp;
   logic [POS_W:0]     calc;
   logic [POS_W-1:0]   calc_target;
   logic               calc_jump;

   // Next tile around the ring, wrapping from the last tile back to 0.
   function automatic logic [POS_W-1:0] step_ring(input logic [POS_W-1:0] p);
      return (p == LAST) ? '0 : p + ONE;
   endfunction

   // Tile the active chicken lands on; skips the opponent's tile (jump).
   // Returned as {jump, target}.
   function automatic logic [POS_W:0] next_target(input logic [POS_W-1:0] o,
                                                  input logic [POS_W-1:0] q);
      logic [POS_W-1:0] t1;
      t1 = step_ring(o);
      if (t1 == q) return {1'b1, step_ring(t1)};
      else         return {1'b0, t1};
   endfunction

   assign own         = turn_q ? pos1_q : pos0_q;
   assign opp         = turn_q ? pos0_q : pos1_q;
   assign calc        = next_target(own, opp);
   assign calc_jump   = calc[POS_W];
   assign calc_target = calc[POS_W-1:0];

   // Next-state and next-output logic for the request FSM.
   always_comb begin
      state_d  = state_q;
      go_d     = go_q;
      win_d    = win_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      turn_d   = turn_q;
      pos0_d   = pos0_q;
      pos1_d   = pos1_q;
      target_d = target_q;
      jump_d   = jump_q;
      card_d   = card_q;
      tile_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (!win_q && A) begin
               card_d  = card_pic;
               state_d = JUDGE;
               busy_d  = 1'b1;
            end else if (!win_q && B && go_q) begin
               state_d = MOVE;
               busy_d  = 1'b1;
            end else if (tile_we && ({1'b0, tile_addr} < NT_EXT)) begin
               tile_wr = 1'b1;
            end
         end
         JUDGE: begin
            target_d = calc_target;
            jump_d   = calc_jump;
            go_d     = (tiles[calc_target[AW-1:0]] == card_q);
            if (tiles[calc_target[AW-1:0]] != card_q) turn_d = ~turn_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         MOVE: begin
            if (turn_q) pos1_d = target_q;
            else        pos0_d = target_q;
            win_d   = win_q | jump_q;
            go_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and position registers; reset aborts any request in flight.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         go_q     <= 1'b0;
         win_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         turn_q   <= 1'b0;
         pos0_q   <= '0;
         pos1_q   <= HALF;
         target_q <= '0;
         jump_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         go_q     <= go_d;
         win_q    <= win_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         turn_q   <= turn_d;
         pos0_q   <= pos0_d;
         pos1_q   <= pos1_d;
         target_q <= target_d;
         jump_q   <= jump_d;
      end
   end

   // Latched card picture; pure data, only loaded when a judge is accepted.
   always_ff @(posedge CLK) begin
      card_q <= card_d;
   end

   // Board layout memory; survives reset so a new game reuses the layout.
   always_ff @(posedge CLK) begin
      if (RST_N && tile_wr) tiles[tile_addr[AW-1:0]] <= tile_pic;
   end

   assign go   = go_q;
   assign win  = win_q;
   assign done = done_q;
   assign busy = busy_q;
   assign turn = turn_q;
   assign pos0 = pos0_q;
   assign pos1 = pos1_q;

endmodule

// File: tb/tb_chicken_judge.sv
// Directed testbench for chicken_judge on an 8-tile board, tiles pic[i]=i.
module tb_chicken_judge;

   localparam int N_TILES = 8;
   localparam int PIC_W   = 4;
   localparam int POS_W   = 5;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             A, B, tile_we;
   logic [PIC_W-1:0] card_pic, tile_pic;
   logic [POS_W-1:0] tile_addr;
   logic             go, win, done, busy, turn;
   logic [POS_W-1:0] pos0, pos1;

   int tests = 0;
   int fails = 0;

   chicken_judge #(.N_TILES(N_TILES), .PIC_W(PIC_W), .POS_W(POS_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .card_pic(card_pic),
      .tile_we(tile_we), .tile_addr(tile_addr), .tile_pic(tile_pic),
      .go(go), .win(win), .done(done), .busy(busy), .turn(turn),
      .pos0(pos0), .pos1(pos1)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
   endtask

   task automatic judge(input string tag, input logic [PIC_W-1:0] c,
                        input logic exp_go, input logic exp_turn);
      A = 1'b1; card_pic = c;
      tick();
      A = 1'b0;
      check({tag, ".busy"}, busy, 1);
      check({tag, ".done0"}, done, 0);
      tick();
      check({tag, ".done"}, done, 1);
      check({tag, ".go"}, go, exp_go);
      check({tag, ".turn"}, turn, exp_turn);
      check({tag, ".idle"}, busy, 0);
   endtask

   task automatic move(input string tag, input logic [POS_W-1:0] e0,
                       input logic [POS_W-1:0] e1, input logic exp_win);
      B = 1'b1;
      tick();
      B = 1'b0;
      check({tag, ".busy"}, busy, 1);
      tick();
      check({tag, ".done"}, done, 1);
      check({tag, ".pos0"}, pos0, e0);
      check({tag, ".pos1"}, pos1, e1);
      check({tag, ".win"}, win, exp_win);
      check({tag, ".go"}, go, 0);
   endtask

   initial begin
      RST_N = 1'b0; A = 1'b0; B = 1'b0; tile_we = 1'b0;
      card_pic = '0; tile_pic = '0; tile_addr = '0;
      tick(); tick();
      RST_N = 1'b1;
      check("rst.go", go, 0);
      check("rst.win", win, 0);
      check("rst.done", done, 0);
      check("rst.busy", busy, 0);
      check("rst.turn", turn, 0);
      check("rst.pos0", pos0, 0);
      check("rst.pos1", pos1, 4);

      for (int i = 0; i < N_TILES; i++) begin
         tile_we = 1'b1; tile_addr = POS_W'(i); tile_pic = PIC_W'(i);
         tick();
      end
      tile_we = 1'b0;

      // judge hit then advance
      judge("hit", 4'd1, 1'b1, 1'b0);
      move("adv", 5'd1, 5'd4, 1'b0);

      // judge miss: target 2 holds pic 2, card 5
      judge("miss", 4'd5, 1'b0, 1'b1);
      check("miss.pos0", pos0, 1);
      check("miss.pos1", pos1, 4);
      B = 1'b1;
      tick();
      B = 1'b0;
      check("miss.b_busy", busy, 0);
      check("miss.b_done", done, 0);
      tick();
      check("miss.b_done2", done, 0);

      // player 1 wraps 4 -> 5 -> 6 -> 7 -> 0
      judge("w5", 4'd5, 1'b1, 1'b1);
      move("w5m", 5'd1, 5'd5, 1'b0);
      judge("w6", 4'd6, 1'b1, 1'b1);
      move("w6m", 5'd1, 5'd6, 1'b0);
      judge("w7", 4'd7, 1'b1, 1'b1);
      move("w7m", 5'd1, 5'd7, 1'b0);
      judge("w0", 4'd0, 1'b1, 1'b1);
      move("w0m", 5'd1, 5'd0, 1'b0);

      // new game (layout retained): player 0 walks to 3, then jumps 4
      do_reset();
      check("rst2.pos1", pos1, 4);
      judge("s1", 4'd1, 1'b1, 1'b0);
      move("s1m", 5'd1, 5'd4, 1'b0);
      judge("s2", 4'd2, 1'b1, 1'b0);
      move("s2m", 5'd2, 5'd4, 1'b0);
      judge("s3", 4'd3, 1'b1, 1'b0);
      move("s3m", 5'd3, 5'd4, 1'b0);
      judge("jump", 4'd5, 1'b1, 1'b0);
      move("jumpm", 5'd5, 5'd4, 1'b1);

      // after win: A and B ignored, tile write accepted
      A = 1'b1; card_pic = 4'd6;
      tick();
      A = 1'b0;
      check("won.a_busy", busy, 0);
      tick();
      check("won.a_done", done, 0);
      B = 1'b1;
      tick();
      B = 1'b0;
      check("won.b_busy", busy, 0);
      check("won.pos0", pos0, 5);
      tile_we = 1'b1; tile_addr = 5'd1; tile_pic = 4'd9;
      tick();
      tile_we = 1'b0;
      check("won.win", win, 1);
      do_reset();
      check("rst3.win", win, 0);
      judge("wr9", 4'd9, 1'b1, 1'b0);

      // A and B together: only the judge runs (card 0 misses tile 1)
      A = 1'b1; B = 1'b1; card_pic = 4'd0;
      tick();
      A = 1'b0; B = 1'b0;
      check("ab.busy", busy, 1);
      tick();
      check("ab.done", done, 1);
      check("ab.go", go, 0);
      check("ab.turn", turn, 1);
      check("ab.pos0", pos0, 0);
      tick();
      check("ab.pulse", done, 0);

      // A held during busy: second request ignored
      A = 1'b1; card_pic = 4'd5;
      tick();
      card_pic = 4'd7;
      tick();
      A = 1'b0;
      check("hold.done", done, 1);
      check("hold.go", go, 1);
      tick();
      check("hold.done2", done, 0);
      check("hold.busy2", busy, 0);

      // reset during JUDGE aborts it
      A = 1'b1; card_pic = 4'd0;
      tick();
      A = 1'b0;
      check("abort.busy", busy, 1);
      RST_N = 1'b0;
      tick();
      check("abort.done", done, 0);
      check("abort.busy0", busy, 0);
      check("abort.go", go, 0);
      check("abort.turn", turn, 0);
      check("abort.pos0", pos0, 0);
      check("abort.pos1", pos1, 4);
      RST_N = 1'b1;
      tick();
      check("abort.done2", done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/chicken_judge.md
Name: chicken_judge

Overview:
- Game-rules datapath that answers the board control FSM's requests. It is the responder side of the control handshake.
- Request A (judge) compares the flipped card picture with the board tile ahead of the current player's chicken and returns go.
- Request B (advance) moves the chicken onto that tile and returns win when the chicken jumps over the opponent.
- Also holds the board tile layout, both chicken positions and the turn flag.

Parameters:
- N_TILES, 24, number of board tiles (ring); must be >= 4.
- PIC_W, 4, picture code width.
- POS_W, 5, position width; must satisfy 2^POS_W >= N_TILES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous reset, active-low.
- A  in  1  judge request; sampled every edge.
- B  in  1  advance request; sampled every edge.
- card_pic  in  PIC_W  picture of the flipped card; sampled with A.
- tile_we  in  1  board layout write enable.
- tile_addr  in  POS_W  board layout write address.
- tile_pic  in  PIC_W  board layout write data.
- go  out  1  1 = last judge matched.
- win  out  1  sticky game-over flag.
- done  out  1  one-cycle pulse: judge or advance result is valid.
- busy  out  1  request in progress.
- turn  out  1  current player (0/1).
- pos0  out  POS_W  player 0 tile index.
- pos1  out  POS_W  player 1 tile index.

Behaviour:
- Reset, when RST_N=0 at an edge:
  - state=IDLE, go=0, win=0, done=0, busy=0, turn=0, pos0=0, pos1=N_TILES/2, target register=0.
  - The tile array is NOT reset; its contents are retained.
- States: IDLE, JUDGE, MOVE. All outputs are registered.
- Target computation:
  - own = pos[turn], opp = pos[~turn].
  - t1 = (own+1) mod N_TILES.
  - If t1 == opp: target = (own+2) mod N_TILES and jump=1. Otherwise target = t1 and jump=0.
  - Wrap-around is explicit, e.g. own=N_TILES-1 gives t1=0.
- IDLE:
  - done=0, busy=0.
  - Priority: win=1 > A > B > tile_we.
  - win=1: A and B are ignored; tile_we is still accepted.
  - A=1: latch card_pic, go to JUDGE, busy=1. B and tile_we in the same cycle are ignored.
  - B=1 with go=1: go to MOVE, busy=1.
  - B=1 with go=0: ignored, no done pulse.
  - tile_we=1: tile[tile_addr] <= tile_pic. Addresses >= N_TILES are ignored.
- JUDGE (one cycle):
  - Compute target/jump and latch both.
  - go <= (tile[target] == latched card).
  - On a miss, turn toggles in the same edge.
  - done=1 for exactly one cycle. Return to IDLE.
- MOVE (one cycle):
  - pos[turn] <= latched target.
  - win <= win | latched jump.
  - go <= 0, so a second B without a new A is ignored.
  - done=1. Return to IDLE.
  - turn does not change on a successful move; the same player flips again.
- Latency:
  - A sampled at edge k: busy=1 after edge k; done=1 and go valid after edge k+1; busy=0 after edge k+1.
  - Same timing for B.
- go holds its value after done until the next JUDGE or MOVE.
- A/B/tile_we while busy=1 are ignored (not queued).
- Reset mid-operation aborts: no pos/turn update; done is not asserted in the reset cycle.
- win is cleared only by reset.

Test Plan (N_TILES=8, tiles loaded pic[i]=i):
- Reset -> go=0, win=0, done=0, busy=0, turn=0, pos0=0, pos1=4.
- Judge hit:
  - A with card_pic=1 -> busy=1 next cycle, then done=1, go=1, turn=0.
  - Then B -> done=1, pos0=1, go=0, win=0.
- Judge miss:
  - card_pic=5 with pos0=1 (target 2) -> done=1, go=0, turn=1, pos unchanged.
  - Following B is ignored: no done, no busy.
- Wrap:
  - Drive player 1 from pos1=4 through 5, 6, 7 to 0, matching each target.
  - Final step: A card_pic=0, B -> pos1=0.
- Jump/win:
  - Setup pos0=3, pos1=4, turn=0.
  - A card_pic=5 -> go=1 (target 5 skips occupied 4); B -> pos0=5, win=1.
  - Subsequent A and B are ignored; tile_we is still accepted.
- Collisions:
  - A and B in the same IDLE cycle -> only the judge runs.
  - A during busy -> ignored.
  - RST_N=0 during JUDGE -> reset values, no done.
